l2_read_stage: RTL

- Generalised L2 pipeline data-read stage, between the directory stage and the response/writeback stage.
- Issues the cache-line SRAM read: the hit way on a hit, or the fill way on a miss with fill data, so a dirty victim can be written back.
- Registers all request state, selects the dirty bit for the addressed way and tracks per-strand load-sync reservations.
- Way count, set count, line width and strand count are parameters; reservations are also cleared on line eviction, and SRAM read is stall-gated.

---
 rtl/l2_cache_pkg.sv | 39 +++
 rtl/l2_sync_reservations.sv | 51 +++++
 rtl/sram_1r1w.sv | 25 ++
 rtl/l2_read_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared L2 cache types: request record, op encodings and derived geometry.
package l2_cache_pkg;

    localparam int L2_NUM_WAYS      = 4;
    localparam int L2_NUM_SETS      = 128;
    localparam int L2_LINE_BITS     = 512;
    localparam int L2_ADDR_WIDTH    = 26;
    localparam int L2_TOTAL_STRANDS = 16;
    localparam int L2_NUM_CORES     = 4;

    localparam int L2_WAY_W    = $clog2(L2_NUM_WAYS);
    localparam int L2_SET_W    = $clog2(L2_NUM_SETS);
    localparam int L2_TAG_W    = L2_ADDR_WIDTH - L2_SET_W;
    localparam int L2_IDX_W    = L2_WAY_W + L2_SET_W;
    localparam int L2_STRAND_W = $clog2(L2_TOTAL_STRANDS);
    localparam int L2_CORE_W   = $clog2(L2_NUM_CORES);
    localparam int L2_MASK_W   = L2_LINE_BITS / 8;

    typedef enum logic [2:0] {
        L2REQ_LOAD        = 3'd0,
        L2REQ_STORE       = 3'd1,
        L2REQ_FLUSH       = 3'd2,
        L2REQ_DINVALIDATE = 3'd3,
        L2REQ_LOAD_SYNC   = 3'd4,
        L2REQ_STORE_SYNC  = 3'd5,
        L2REQ_IINVALIDATE = 3'd6
    } l2req_op_t;

    typedef struct packed {
        logic [L2_CORE_W-1:0]     unit;
        logic [L2_STRAND_W-1:0]   strand;
        l2req_op_t                op;
        logic [L2_WAY_W-1:0]      way;
        logic [L2_ADDR_WIDTH-1:0] address;
        logic [L2_LINE_BITS-1:0]  data;
        logic [L2_MASK_W-1:0]     mask;
    } l2req_t;

endpackage

// File: rtl/l2_sync_reservations.sv
// Per-strand load-sync reservation table with store and eviction invalidation.
module l2_sync_reservations
    import l2_cache_pkg::*;
#(
    parameter int TOTAL_STRANDS = L2_TOTAL_STRANDS,
    parameter int ADDR_WIDTH    = L2_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_enable,
    input  logic                             i_access,
    input  l2req_op_t                        i_op,
    input  logic [$clog2(TOTAL_STRANDS)-1:0] i_strand,
    input  logic [ADDR_WIDTH-1:0]            i_addr,
    input  logic                             i_evict,
    input  logic [ADDR_WIDTH-1:0]            i_evict_addr,
    output logic                             o_can_sync
);

    localparam int STRAND_W = $clog2(TOTAL_STRANDS);

    logic [TOTAL_STRANDS-1:0] r_valid;
    logic [ADDR_WIDTH-1:0]    r_addr [TOTAL_STRANDS];
    logic                     w_store_clear;

    assign o_can_sync = (i_op == L2REQ_STORE_SYNC) && r_valid[i_strand]
                        && (r_addr[i_strand] == i_addr);

    // A failed STORE_SYNC must not clear other strands, or two strands can livelock.
    assign w_store_clear = i_access && ((i_op == L2REQ_STORE)
                           || ((i_op == L2REQ_STORE_SYNC) && o_can_sync));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < TOTAL_STRANDS; i++)
                r_addr[i] <= '0;
        end else if (i_enable) begin
            for (int i = 0; i < TOTAL_STRANDS; i++) begin
                if (i_access && (i_op == L2REQ_LOAD_SYNC) && (i_strand == STRAND_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_addr[i]  <= i_addr;
                end else if ((w_store_clear && (r_addr[i] == i_addr))
                             || (i_evict && (r_addr[i] == i_evict_addr))) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sram_1r1w.sv
// One-read/one-write synchronous SRAM; a same-cycle read returns the old contents.
module sram_1r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 64,
    parameter int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    logic [DATA_WIDTH-1:0] r_mem [SIZE];

    always_ff @(posedge clk) begin
        if (write_en)
            r_mem[write_addr] <= write_data;
        if (read_en)
            read_data <= r_mem[read_addr];
    end

endmodule

// File: rtl/l2_read_stage.sv
// L2 data-read stage: registers request state and reads the hit/fill cache line.
// Optional macro L2_READ_BYPASS_EN forwards same-index write data into rd_cache_data.
module l2_read_stage
    import l2_cache_pkg::*;
#(
    parameter int NUM_WAYS      = L2_NUM_WAYS,
    parameter int NUM_SETS      = L2_NUM_SETS,
    parameter int LINE_BITS     = L2_LINE_BITS,
    parameter int ADDR_WIDTH    = L2_ADDR_WIDTH,
    parameter int TOTAL_STRANDS = L2_TOTAL_STRANDS,
    parameter int NUM_CORES     = L2_NUM_CORES
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              stall_pipeline,
    input  logic                                              dir_valid,
    input  l2req_t                                            dir_req,
    input  logic                                              dir_has_sm_data,
    input  logic [LINE_BITS-1:0]                              dir_sm_data,
    input  logic                                              dir_cache_hit,
    input  logic [$clog2(NUM_WAYS)-1:0]                       dir_hit_way,
    input  logic [$clog2(NUM_WAYS)-1:0]                       dir_replace_way,
    input  logic [$clog2(NUM_WAYS)-1:0]                       dir_sm_fill_way,
    input  logic [ADDR_WIDTH-$clog2(NUM_SETS)-1:0]            dir_old_tag,
    input  logic [NUM_WAYS-1:0]                               dir_dirty,
    input  logic [NUM_CORES-1:0]                              dir_l1_has_line,
    input  logic [NUM_CORES*2-1:0]                            dir_l1_way,
    input  logic                                              wr_update_enable,
    input  logic [$clog2(NUM_WAYS)+$clog2(NUM_SETS)-1:0]      wr_cache_index,
    input  logic [LINE_BITS-1:0]                              wr_update_data,
    output logic                                              rd_valid,
    output l2req_t                                            rd_req,
    output logic                                              rd_has_sm_data,
    output logic [LINE_BITS-1:0]                              rd_sm_data,
    output logic [$clog2(NUM_WAYS)-1:0]                       rd_sm_fill_way,
    output logic [$clog2(NUM_WAYS)-1:0]                       rd_hit_way,
    output logic [$clog2(NUM_WAYS)-1:0]                       rd_replace_way,
    output logic                                              rd_cache_hit,
    output logic [NUM_CORES-1:0]                              rd_l1_has_line,
    output logic [NUM_CORES*2-1:0]                            rd_l1_way,
    output logic [ADDR_WIDTH-$clog2(NUM_SETS)-1:0]            rd_old_tag,
    output logic                                              rd_line_is_dirty,
    output logic                                              rd_store_sync_success,
    output logic [LINE_BITS-1:0]                              rd_cache_data
);

    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int IDX_W = WAY_W + SET_W;

    logic                 w_access;
    logic                 w_rd_en;
    logic                 w_wr_en;
    logic                 w_evict;
    logic                 w_can_sync;
    logic [SET_W-1:0]     w_set;
    logic [WAY_W-1:0]     w_rd_way;
    logic [WAY_W-1:0]     w_dirty_way;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [LINE_BITS-1:0] w_sram_data;

    assign w_access    = dir_valid && (dir_cache_hit || dir_has_sm_data);
    assign w_set       = dir_req.address[SET_W-1:0];
    assign w_rd_way    = dir_cache_hit ? dir_hit_way : dir_sm_fill_way;
    assign w_rd_idx    = {w_rd_way, w_set};
    assign w_rd_en     = w_access && !stall_pipeline;
    assign w_wr_en     = wr_update_enable && !stall_pipeline;
    assign w_evict     = dir_valid && !dir_cache_hit && dir_has_sm_data;
    assign w_dirty_way = (dir_req.op == L2REQ_FLUSH) ? dir_hit_way : dir_sm_fill_way;

    l2_sync_reservations #(
        .TOTAL_STRANDS (TOTAL_STRANDS),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_resv (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (!stall_pipeline),
        .i_access     (w_access),
        .i_op         (dir_req.op),
        .i_strand     (dir_req.strand),
        .i_addr       (dir_req.address),
        .i_evict      (w_evict),
        .i_evict_addr ({dir_old_tag, w_set}),
        .o_can_sync   (w_can_sync)
    );

    // Miss reads target the fill way so a dirty victim can be written back.
    sram_1r1w #(
        .DATA_WIDTH (LINE_BITS),
        .SIZE       (NUM_WAYS * NUM_SETS)
    ) u_data_sram (
        .clk        (clk),
        .read_en    (w_rd_en),
        .read_addr  (w_rd_idx),
        .read_data  (w_sram_data),
        .write_en   (w_wr_en),
        .write_addr (wr_cache_index),
        .write_data (wr_update_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid              <= 1'b0;
            rd_req                <= '0;
            rd_has_sm_data        <= 1'b0;
            rd_sm_data            <= '0;
            rd_sm_fill_way        <= '0;
            rd_hit_way            <= '0;
            rd_replace_way        <= '0;
            rd_cache_hit          <= 1'b0;
            rd_l1_has_line        <= '0;
            rd_l1_way             <= '0;
            rd_old_tag            <= '0;
            rd_line_is_dirty      <= 1'b0;
            rd_store_sync_success <= 1'b0;
        end else if (!stall_pipeline) begin
            rd_valid              <= dir_valid;
            rd_req                <= dir_req;
            rd_has_sm_data        <= dir_has_sm_data;
            rd_sm_data            <= dir_sm_data;
            rd_sm_fill_way        <= dir_sm_fill_way;
            rd_hit_way            <= dir_hit_way;
            rd_replace_way        <= dir_replace_way;
            rd_cache_hit          <= dir_cache_hit;
            rd_l1_has_line        <= dir_l1_has_line;
            rd_l1_way             <= dir_l1_way;
            rd_old_tag            <= dir_old_tag;
            rd_line_is_dirty      <= dir_dirty[w_dirty_way];
            rd_store_sync_success <= w_access ? w_can_sync : 1'b0;
        end
    end

`ifdef L2_READ_BYPASS_EN
    logic                 r_bypass;
    logic [LINE_BITS-1:0] r_bypass_data;
    logic                 w_bypass_hit;

    assign w_bypass_hit = w_wr_en && (wr_cache_index == w_rd_idx);

    // Only a real read moves the SRAM output, so the bypass flag follows reads too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_bypass <= 1'b0;
        else if (w_rd_en)
            r_bypass <= w_bypass_hit;
    end

    always_ff @(posedge clk) begin
        if (w_rd_en && w_bypass_hit)
            r_bypass_data <= wr_update_data;
    end

    assign rd_cache_data = r_bypass ? r_bypass_data : w_sram_data;
`else
    assign rd_cache_data = w_sram_data;
`endif

endmodule
